imem_boot_loader: RTL and testbench

- Boot-time program loader for the single-cycle core's instruction memory.
- Accepts a framed byte stream over a valid/ready handshake and packs it into 32-bit little-endian words.
- Writes each word to instruction memory at byte-address steps of 4 and holds the CPU until the load is verified.
- Sits between the host/UART byte source and the instruction memory write port; drives the core's hold line.

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_boot_loader_if.sv | 11 +
 rtl/imem_word_packer.sv | 36 +++
 rtl/imem_boot_loader.sv | 119 +++++++++++
 tb/tb_imem_boot_loader.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Imported by the word packer and the loader top.
package imem_loader_pkg;

    localparam int WORD_BYTES        = 4;
    localparam int DEFAULT_MAX_WORDS = 16;
    localparam int COUNT_W           = 5;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
        WRITE,
        CHECK,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream valid/ready handshake between the host byte source and the loader.
interface imem_boot_loader_if;

    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_in, output byte_valid, input  byte_ready);
    modport slave  (input  byte_in, input  byte_valid, output byte_ready);

endinterface

// File: rtl/imem_word_packer.sv
// Packs little-endian bytes into 32-bit words and keeps a running XOR of every
// byte accepted since the last clear.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  byte_in,
    output logic        word_full,
    output logic [31:0] word,
    output logic [7:0]  checksum
);

    logic [1:0] lane;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lane     <= '0;
            word     <= '0;
            checksum <= '0;
        end else if (load) begin
            word[{lane, 3'b000} +: 8] <= byte_in;
            checksum                  <= checksum ^ byte_in;
            lane                      <= lane + 2'd1;
        end
    end

    // Asserted on the transfer that fills the top lane; the word is complete
    // in the register on the following cycle.
    assign word_full = load && (lane == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// Boot-time loader: receives a framed byte stream, writes packed words to
// instruction memory and holds the core until the frame checksum verifies.
module imem_boot_loader
    import imem_loader_pkg::*;
#(
    parameter int                MAX_WORDS = DEFAULT_MAX_WORDS,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    imem_boot_loader_if.slave    stream,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_waddr,
    output logic [31:0]          mem_wdata,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 error,
    output logic [COUNT_W-1:0]   words_loaded
);

    state_t              state;
    state_t              next_state;
    logic [COUNT_W-1:0]  word_count;
    logic [ADDR_W-1:0]   last_waddr;
    logic [31:0]         last_wdata;
    logic [ADDR_W-1:0]   wr_addr;
    logic [31:0]         packed_word;
    logic [7:0]          checksum;
    logic                word_full;
    logic                xfer;
    logic                restart;
    logic                count_bad;
    logic                last_word;

    assign xfer      = stream.byte_valid && stream.byte_ready;
    assign restart   = start && (state inside {IDLE, DONE, ERR});
    assign count_bad = (stream.byte_in == 8'd0) || (int'(stream.byte_in) > MAX_WORDS);
    assign last_word = ((words_loaded + COUNT_W'(1)) == word_count);
    assign wr_addr   = BASE_ADDR + (ADDR_W'(words_loaded) << 2);

    imem_word_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (restart),
        .load      ((state == DATA) && xfer),
        .byte_in   (stream.byte_in),
        .word_full (word_full),
        .word      (packed_word),
        .checksum  (checksum)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE, DONE, ERR: if (start) next_state = COUNT;
            COUNT:           if (xfer)  next_state = count_bad ? ERR : DATA;
            DATA:            if (word_full) next_state = WRITE;
            WRITE:           next_state = last_word ? CHECK : DATA;
            CHECK:           if (xfer) next_state = (stream.byte_in == checksum) ? DONE : ERR;
            default:         next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_count   <= '0;
            words_loaded <= '0;
            last_waddr   <= '0;
            last_wdata   <= '0;
        end else begin
            if (restart) begin
                word_count   <= '0;
                words_loaded <= '0;
            end
            if ((state == COUNT) && xfer) word_count <= stream.byte_in[COUNT_W-1:0];
            if (state == WRITE) begin
                last_waddr <= wr_addr;
                last_wdata <= packed_word;
                if (words_loaded != COUNT_W'(MAX_WORDS)) words_loaded <= words_loaded + COUNT_W'(1);
            end
        end
    end

    // Address and data are driven live during WRITE and otherwise hold the
    // values of the most recent write.
    always_comb begin
        stream.byte_ready = 1'b0;
        mem_we            = 1'b0;
        mem_waddr         = last_waddr;
        mem_wdata         = last_wdata;
        cpu_hold          = 1'b1;
        done              = 1'b0;
        error             = 1'b0;
        unique case (state)
            COUNT, DATA, CHECK: stream.byte_ready = 1'b1;
            WRITE: begin
                mem_we    = 1'b1;
                mem_waddr = wr_addr;
                mem_wdata = packed_word;
            end
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            ERR:     error = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader.
module tb_imem_boot_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [4:0]  words_loaded;

    int total = 0;
    int bad   = 0;
    int ready_in_write = 0;
    logic [63:0] wr_q[$];

    imem_boot_loader_if bus ();

    imem_boot_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stream       (bus),
        .mem_we       (mem_we),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-port monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (mem_we) wr_q.push_back({mem_waddr, mem_wdata});
        if (mem_we && bus.byte_ready) ready_in_write++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        repeat (gap) tick();
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (bus.byte_ready) ok = 1'b1;
            tick();
        end
        bus.byte_valid = 1'b0;
        if (!ok) check("byte_accept_timeout", 64'(ok), 64'd1);
    endtask

    task automatic send_seq(input logic [7:0] bytes[$], input int gap);
        foreach (bytes[i]) send_byte(bytes[i], gap);
    endtask

    task automatic check_write(input string tag, input int idx,
                               input logic [31:0] addr, input logic [31:0] data);
        logic [63:0] got;
        got = (idx < wr_q.size()) ? wr_q[idx] : '1;
        check(tag, got, {addr, data});
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 64'(bus.byte_ready), 64'd0);
        check({tag, "_we"},    64'(mem_we),         64'd0);
        check({tag, "_waddr"}, 64'(mem_waddr),      64'd0);
        check({tag, "_wdata"}, 64'(mem_wdata),      64'd0);
        check({tag, "_hold"},  64'(cpu_hold),       64'd1);
        check({tag, "_done"},  64'(done),           64'd0);
        check({tag, "_error"}, 64'(error),          64'd0);
        check({tag, "_words"}, 64'(words_loaded),   64'd0);
    endtask

    logic [7:0] data2[$];
    logic [7:0] dbeef[$];
    logic [7:0] cs2;

    initial begin
        reset          = 1'b1;
        start          = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        data2 = '{8'h33, 8'h04, 8'h74, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00};
        dbeef = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        cs2 = 8'h00;
        foreach (data2[i]) cs2 ^= data2[i];

        tick();
        tick();
        check_reset_values("rst");
        reset = 1'b0;
        tick();

        // Basic two-word load with the correct XOR checksum.
        wr_q.delete();
        pulse_start();
        check("t1_ready_count", 64'(bus.byte_ready), 64'd1);
        send_byte(8'h02, 0);
        send_seq(data2[0:3], 0);
        check("t1_we_latency", 64'(mem_we), 64'd1);
        send_seq(data2[4:7], 0);
        send_byte(cs2, 0);
        check("t1_nwr", 64'(wr_q.size()), 64'd2);
        check_write("t1_w0", 0, 32'h0000_0000, 32'h0074_0433);
        check_write("t1_w1", 1, 32'h0000_0004, 32'h0050_0513);
        check("t1_done",  64'(done),         64'd1);
        check("t1_hold",  64'(cpu_hold),     64'd0);
        check("t1_error", 64'(error),        64'd0);
        check("t1_words", 64'(words_loaded), 64'd2);

        // Same frame with a wrong checksum byte.
        wr_q.delete();
        pulse_start();
        send_byte(8'h02, 0);
        send_seq(data2, 0);
        send_byte(8'h00, 0);
        check("t2_nwr",   64'(wr_q.size()), 64'd2);
        check("t2_error", 64'(error),       64'd1);
        check("t2_hold",  64'(cpu_hold),    64'd1);
        check("t2_done",  64'(done),        64'd0);

        // Illegal word counts.
        wr_q.delete();
        pulse_start();
        send_byte(8'h00, 0);
        repeat (3) tick();
        check("t3_error", 64'(error),       64'd1);
        check("t3_nwr",   64'(wr_q.size()), 64'd0);
        pulse_start();
        send_byte(8'h11, 0);
        repeat (3) tick();
        check("t4_error", 64'(error),       64'd1);
        check("t4_nwr",   64'(wr_q.size()), 64'd0);

        // MAX_WORDS itself is a legal count.
        pulse_start();
        check("t5_err_cleared", 64'(error), 64'd0);
        send_byte(8'h10, 0);
        check("t5_error", 64'(error),          64'd0);
        check("t5_ready", 64'(bus.byte_ready), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // One word with three idle cycles before every byte.
        wr_q.delete();
        ready_in_write = 0;
        pulse_start();
        send_byte(8'h01, 3);
        send_seq(dbeef, 3);
        check("t6_we",        64'(mem_we),          64'd1);
        check("t6_ready_wr",  64'(bus.byte_ready),  64'd0);
        send_byte(8'h22, 3);
        check("t6_nwr", 64'(wr_q.size()), 64'd1);
        check_write("t6_w0", 0, 32'h0000_0000, 32'hDEAD_BEEF);
        check("t6_ready_in_write", 64'(ready_in_write), 64'd0);
        check("t6_done", 64'(done), 64'd1);

        // Reset after the sixth byte of a two-word frame, then a clean reload.
        pulse_start();
        send_byte(8'h02, 0);
        send_seq(data2[0:4], 0);
        check("t7_words_pre", 64'(words_loaded), 64'd1);
        reset = 1'b1;
        tick();
        check_reset_values("t7_rst");
        reset = 1'b0;
        tick();
        wr_q.delete();
        pulse_start();
        send_byte(8'h02, 0);
        send_seq(data2, 0);
        send_byte(cs2, 0);
        check_write("t7_w0", 0, 32'h0000_0000, 32'h0074_0433);
        check_write("t7_w1", 1, 32'h0000_0004, 32'h0050_0513);
        check("t7_done", 64'(done), 64'd1);

        // Restart from DONE; a start during DATA is ignored.
        wr_q.delete();
        pulse_start();
        check("t8_done_clr",  64'(done),         64'd0);
        check("t8_words_clr", 64'(words_loaded), 64'd0);
        send_byte(8'h01, 0);
        send_seq(dbeef[0:1], 0);
        pulse_start();
        check("t8_ign_ready", 64'(bus.byte_ready), 64'd1);
        check("t8_ign_error", 64'(error),          64'd0);
        send_seq(dbeef[2:3], 0);
        send_byte(8'h22, 0);
        check("t8_nwr", 64'(wr_q.size()), 64'd1);
        check_write("t8_w0", 0, 32'h0000_0000, 32'hDEAD_BEEF);
        check("t8_done",  64'(done),         64'd1);
        check("t8_words", 64'(words_loaded), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
